// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller slice: timer state
// encoding and default sizing for the interval timer.
package tlc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } timer_state_t;

   // 1 MHz system clock gives one tick per second
   localparam int DEFAULT_TICK_DIV = 1000000;
   localparam int VAL_W            = 4;

endpackage : tlc_pkg

// File: rtl/tick_gen.sv
// Seconds prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last
// one with a single-cycle tick. A synchronous clear restarts the count.
module tick_gen
   import tlc_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tick = enable && (count == LAST);

endmodule : tick_gen

// File: rtl/interval_timer.sv
// Countdown timer for the traffic-light controller: loads the interval in
// seconds one cycle after start_timer and pulses expired when it runs out.
module interval_timer
   import tlc_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV,
   parameter int VAL_W    = tlc_pkg::VAL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_timer,
   input  logic             abort,
   input  logic [VAL_W-1:0] value,
   output logic             expired,
   output logic             busy,
   output logic [VAL_W-1:0] remaining
);

   timer_state_t state_q;
   timer_state_t state_d;
   logic         tick;
   logic         presc_clear;
   logic         presc_enable;

   // The prescaler only runs in COUNT, so every interval starts on a fresh second
   assign presc_enable = (state_q == COUNT);
   assign presc_clear  = abort || start_timer || (state_q != COUNT);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (presc_clear),
      .enable (presc_enable),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else if (start_timer) begin
         state_d = LOAD;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            LOAD:    state_d = (value == '0) ? DONE : COUNT;
            COUNT:   state_d = (tick && (remaining == VAL_W'(1))) ? DONE : COUNT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // value is sampled in LOAD because the parameter stage updates it on the start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
      end else if (!abort && !start_timer) begin
         if (state_q == LOAD) begin
            remaining <= value;
         end else if ((state_q == COUNT) && tick && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

   assign expired = (state_q == DONE);
   assign busy    = (state_q == LOAD) || (state_q == COUNT);

endmodule : interval_timer
